// File: rtl/sdp_ram_rd_stream_if.sv
// Stream bundle carried out of sdp_ram_rd_stream: FIFO head word with valid/ready handshake.
interface sdp_ram_rd_stream_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, m_valid, input m_ready);
  modport slave  (input m_data, m_valid, output m_ready);
endinterface

// File: rtl/sdp_ram_rd_stream.sv
// Read sequencer for sdp_sync_ram: streams len words from base_addr through a credit-checked FIFO.
// Optional RD_STREAM_STRIDE_EN adds a stride input that replaces the unit address step.
module sdp_ram_rd_stream #(
  parameter int  DATA_W     = 64,
  parameter int  RAM_DEPTH  = 512,
  parameter int  RD_LAT     = 2,
  parameter int  FIFO_DEPTH = 4,
  parameter int  LEN_W      = 16,
  localparam int AW         = $clog2(RAM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [LEN_W-1:0]    len,
`ifdef RD_STREAM_STRIDE_EN
  input  logic [AW-1:0]       stride,
`endif
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       ram_addr,
  output logic                ram_en,
  output logic                ram_rstb,
  input  logic [DATA_W-1:0]   ram_dout,
  sdp_ram_rd_stream_if.master m
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rd_left_q, out_left_q;
  logic              zero_done_q;
  logic [AW-1:0]     step;
  logic [RD_LAT-1:0] vld_p;
  logic [CW-1:0]     inflight_q, count_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [CW:0]       committed;
  logic              accept, issue, push, pop, credit_ok, last_pop;

`ifdef RD_STREAM_STRIDE_EN
  logic [AW-1:0] step_q;
  assign step = step_q;
`else
  assign step = AW'(1);
`endif

  assign accept    = start && (state_q == S_IDLE);
  // Reads in flight plus words already queued may never exceed the FIFO size.
  assign committed = {1'b0, inflight_q} + {1'b0, count_q};
  assign credit_ok = committed < (CW+1)'(FIFO_DEPTH);
  assign push      = vld_p[RD_LAT-1];
  assign pop       = m.m_valid && m.m_ready;
  assign last_pop  = pop && (out_left_q == LEN_W'(1));

  assign busy      = (state_q != S_IDLE);
  assign ram_en    = busy;
  assign ram_rstb  = 1'b0;
  assign m.m_valid = (count_q != '0);
  assign m.m_data  = fifo_mem[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done    = zero_done_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (len != '0)) state_d = S_RUN;
      end
      S_RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (rd_left_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_left_q   <= '0;
      out_left_q  <= '0;
      ram_addr    <= '0;
      zero_done_q <= 1'b0;
`ifdef RD_STREAM_STRIDE_EN
      step_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      zero_done_q <= accept && (len == '0);
      if (accept) begin
        ram_addr   <= base_addr;
        rd_left_q  <= len;
        out_left_q <= len;
`ifdef RD_STREAM_STRIDE_EN
        step_q     <= stride;
`endif
      end else begin
        if (issue) begin
          ram_addr  <= ram_addr + step;
          rd_left_q <= rd_left_q - LEN_W'(1);
        end
        if (pop) out_left_q <= out_left_q - LEN_W'(1);
      end
    end
  end

  // Stage boundary: issued-read markers travel RD_LAT cycles, matching the RAM pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Stage boundary: returning RAM word lands in the FIFO on the marker's exit cycle.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= ram_dout;
  end

endmodule
